// File: rtl/load_store_unit_if.sv
// Core-side request/response channel of the load/store unit.
// master = execute stage, slave = load_store_unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one transaction at a time against a byte-addressed big-endian RAM.
// Optional MISALIGN_TRAP_EN makes unaligned half/word accesses fault.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus,
  output logic [2:0]         mem_write_enable_o,
  output logic [31:0]        mem_addr_o,
  output logic [31:0]        mem_data_in_o,
  input  logic [31:0]        mem_data_out_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

  state_e      state_q;
  logic        req_ready_q, resp_valid_q, resp_fault_q;
  logic        store_q, unsigned_q;
  logic [1:0]  size_q;
  logic [31:0] resp_rdata_q, mem_addr_q, mem_data_in_q;

  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        misalign, fault_d;
  logic [31:0] load_d;

  // Range check in 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    case (bus.req_size)
      2'd1:    nbytes = 3'd2;
      2'd2:    nbytes = 3'd4;
      default: nbytes = 3'd1;
    endcase
    end_addr = {1'b0, bus.req_addr} + 33'(nbytes);
`ifdef MISALIGN_TRAP_EN
    misalign = (bus.req_size == 2'd1 && bus.req_addr[0]) ||
               (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    fault_d = (bus.req_size == 2'd3) || (end_addr > 33'(MEM_BYTES)) || misalign;
  end

  // RAM returns the addressed byte first, so narrow loads sit in the top bits.
  always_comb begin
    case (size_q)
      2'd0:    load_d = unsigned_q ? {24'h0, mem_data_out_i[31:24]}
                                   : {{24{mem_data_out_i[31]}}, mem_data_out_i[31:24]};
      2'd1:    load_d = unsigned_q ? {16'h0, mem_data_out_i[31:16]}
                                   : {{16{mem_data_out_i[31]}}, mem_data_out_i[31:16]};
      default: load_d = mem_data_out_i;
    endcase
  end

  always_comb begin
    mem_write_enable_o = 3'b000;
    if (state_q == ACCESS && store_q) begin
      case (size_q)
        2'd0:    mem_write_enable_o = 3'b100;
        2'd1:    mem_write_enable_o = 3'b010;
        2'd2:    mem_write_enable_o = 3'b001;
        default: mem_write_enable_o = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_fault_q  <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      store_q       <= 1'b0;
      unsigned_q    <= 1'b0;
      size_q        <= 2'd0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid && req_ready_q) begin
          store_q       <= bus.req_store;
          size_q        <= bus.req_size;
          unsigned_q    <= bus.req_unsigned;
          mem_addr_q    <= bus.req_addr;
          mem_data_in_q <= bus.req_wdata;
          req_ready_q   <= 1'b0;
          if (fault_d) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          resp_rdata_q <= store_q ? 32'h0 : load_d;
          resp_fault_q <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: if (bus.resp_ready) begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_fault  = resp_fault_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_data_in_o   = mem_data_in_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array RAM, transaction-level reference model,
// per-cycle compare process and directed transactions with literal expectations.
module tb_load_store_unit;
  logic        clk, rst;
  logic [2:0]  mem_we;
  logic [31:0] mem_addr, mem_din, mem_dout;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mem_write_enable_o(mem_we), .mem_addr_o(mem_addr),
    .mem_data_in_o(mem_din), .mem_data_out_i(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Data RAM: big-endian, combinational read, write at the clock edge.
  logic [7:0] ram     [0:4095];
  logic [7:0] ref_mem [0:4095];

  always_comb begin
    mem_dout = '0;
    for (int i = 0; i < 4; i++)
      if ({1'b0, mem_addr} + 33'(i) < 33'd4096)
        mem_dout[8*(3-i) +: 8] = ram[mem_addr[11:0] + 12'(i)];
  end

  always @(posedge clk) begin
    if (mem_we[0] && mem_addr <= 32'd4092)
      for (int i = 0; i < 4; i++) ram[mem_addr[11:0] + 12'(i)] = mem_din[8*(3-i) +: 8];
    if (mem_we[1] && mem_addr <= 32'd4094) begin
      ram[mem_addr[11:0]]         = mem_din[15:8];
      ram[mem_addr[11:0] + 12'd1] = mem_din[7:0];
    end
    if (mem_we[2] && mem_addr <= 32'd4095) ram[mem_addr[11:0]] = mem_din[7:0];
  end

  // Reference model: one outstanding transaction with its expected outcome.
  int          cyc = 0;
  bit          m_out = 0, m_fault = 0, m_store = 0;
  logic [1:0]  m_size = 2'd0;
  logic [31:0] m_rdata = '0;
  int          m_acc = 0;

  task automatic model_req(input bit st, input logic [1:0] sz, input bit un,
                           input logic [31:0] a, input logic [31:0] wd);
    int nb;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    m_fault = (sz == 2'd3) || ({1'b0, a} + 33'(nb) > 33'd4096);
`ifdef MISALIGN_TRAP_EN
    if (sz != 2'd3 && (a % nb) != 0) m_fault = 1;
`endif
    m_store = st;
    m_size  = sz;
    m_rdata = '0;
    if (!m_fault) begin
      if (st) begin
        for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*(nb-1-i) +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_mem[int'(a) + i]);
        if (!un && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        m_rdata = v;
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) m_out = 0;
    else if (m_out) begin
      if (cyc >= m_acc + (m_fault ? 0 : 1) && bus.resp_ready) m_out = 0;
    end else if (bus.req_valid) begin
      model_req(bus.req_store, bus.req_size, bus.req_unsigned, bus.req_addr, bus.req_wdata);
      m_out = 1;
      m_acc = cyc + 1;
    end
    cyc++;
  end

  bit         in_rst = 1;
  int         strobe_cnt = 0;
  logic [2:0] last_we = '0;

  always @(negedge clk) begin : cmp
    logic [2:0] exp_we;
    bit mv;
    if (!in_rst) begin
      exp_we = 3'b000;
      if (m_out && !m_fault && m_store && cyc == m_acc)
        exp_we = (m_size == 2'd0) ? 3'b100 : (m_size == 2'd1) ? 3'b010 : 3'b001;
      mv = m_out && (cyc >= m_acc + (m_fault ? 0 : 1));
      if (mem_we != 3'b000) begin
        strobe_cnt++;
        last_we = mem_we;
      end
      chk("req_ready",  32'(bus.req_ready),  32'(!m_out));
      chk("mem_we",     32'(mem_we),         32'(exp_we));
      chk("resp_valid", 32'(bus.resp_valid), 32'(mv));
      if (mv) begin
        chk("resp_rdata", bus.resp_rdata,      m_rdata);
        chk("resp_fault", 32'(bus.resp_fault), 32'(m_fault));
      end
    end
  end

  // Called on a negedge; returns the captured response and its latency in cycles.
  task automatic xact(input bit st, input logic [1:0] sz, input bit un,
                      input logic [31:0] a, input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output bit flt, output int lat);
    int n;
    n = 0;
    while (m_out && n < 20) begin @(negedge clk); n++; end
    bus.req_valid = 1; bus.req_store = st; bus.req_size = sz;
    bus.req_unsigned = un; bus.req_addr = a; bus.req_wdata = wd;
    bus.resp_ready = (hold == 0);
    @(negedge clk);
    bus.req_valid = 0;
    lat = 1; n = 0;
    while (!bus.resp_valid && n < 10) begin @(negedge clk); lat++; n++; end
    if (!bus.resp_valid) begin
      errors++; checks++;
      $display("FAIL resp_timeout: no resp_valid for addr %h", a);
    end
    rd = bus.resp_rdata;
    flt = bus.resp_fault;
    repeat (hold) @(negedge clk);
    bus.resp_ready = 1;
  endtask

  logic [31:0] rd;
  bit          f;
  int          lat;

  initial begin
    rst = 1; bus.req_valid = 0; bus.req_store = 0; bus.req_size = 0;
    bus.req_unsigned = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 1;
    for (int i = 0; i < 4096; i++) begin ram[i] = 8'h00; ref_mem[i] = 8'h00; end
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_req_ready",  32'(bus.req_ready),  1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_we",         32'(mem_we),         0);
    chk("rst_rdata",      bus.resp_rdata,      0);
    chk("rst_fault",      32'(bus.resp_fault), 0);
    chk("rst_mem_addr",   mem_addr,            0);
    chk("rst_mem_din",    mem_din,             0);
    in_rst = 0;

    strobe_cnt = 0;
    xact(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, rd, f, lat);
    chk("stw_fault", 32'(f), 0);
    chk("stw_rdata", rd, 0);
    chk("stw_strobes", 32'(strobe_cnt), 1);
    chk("stw_we", 32'(last_we), 32'b001);
    strobe_cnt = 0;
    xact(0, 2'd2, 0, 32'h10, 32'h0, 0, rd, f, lat);
    chk("ldw_rdata", rd, 32'hDEADBEEF);
    chk("ldw_fault", 32'(f), 0);
    chk("ldw_lat", 32'(lat), 2);
    chk("ldw_strobes", 32'(strobe_cnt), 0);

    xact(1, 2'd0, 0, 32'h21, 32'h80, 0, rd, f, lat);
    chk("stb_we", 32'(last_we), 32'b100);
    xact(0, 2'd0, 0, 32'h21, 32'h0, 0, rd, f, lat);
    chk("ldb_signed", rd, 32'hFFFFFF80);
    xact(0, 2'd0, 1, 32'h21, 32'h0, 0, rd, f, lat);
    chk("ldb_unsigned", rd, 32'h00000080);

    xact(1, 2'd1, 0, 32'h30, 32'h1234A5B6, 0, rd, f, lat);
    chk("sth_we", 32'(last_we), 32'b010);
    xact(0, 2'd1, 0, 32'h30, 32'h0, 0, rd, f, lat);
    chk("ldh_signed", rd, 32'hFFFFA5B6);
    xact(0, 2'd1, 1, 32'h30, 32'h0, 0, rd, f, lat);
    chk("ldh_unsigned", rd, 32'h0000A5B6);

    strobe_cnt = 0;
    xact(0, 2'd1, 0, 32'h0FFF, 32'h0, 0, rd, f, lat);
    chk("ldh_oob_fault", 32'(f), 1);
    chk("ldh_oob_rdata", rd, 0);
    chk("ldh_oob_lat", 32'(lat), 1);
    xact(1, 2'd1, 0, 32'h0FFF, 32'hFFFF, 0, rd, f, lat);
    chk("sth_oob_fault", 32'(f), 1);
    chk("sth_oob_strobes", 32'(strobe_cnt), 0);
    xact(0, 2'd3, 0, 32'h0, 32'h0, 0, rd, f, lat);
    chk("size3_fault", 32'(f), 1);
    xact(0, 2'd2, 0, 32'hFFFF_FFFE, 32'h0, 0, rd, f, lat);
    chk("wrap_fault", 32'(f), 1);
    xact(0, 2'd2, 0, 32'h0FFC, 32'h0, 0, rd, f, lat);
    chk("top_word_fault", 32'(f), 0);

    xact(1, 2'd2, 0, 32'h100, 32'h11223344, 0, rd, f, lat);
    xact(1, 2'd2, 0, 32'h104, 32'h55667788, 0, rd, f, lat);
    xact(0, 2'd2, 0, 32'h102, 32'h0, 0, rd, f, lat);
`ifdef MISALIGN_TRAP_EN
    chk("ldw_mis_fault", 32'(f), 1);
    chk("ldw_mis_rdata", rd, 0);
`else
    chk("ldw_mis_fault", 32'(f), 0);
    chk("ldw_mis_rdata", rd, 32'h33445566);
`endif

    xact(0, 2'd2, 0, 32'h10, 32'h0, 5, rd, f, lat);
    chk("hold_rdata", rd, 32'hDEADBEEF);
    chk("hold_valid", 32'(bus.resp_valid), 1);

    // Reset while a response is pending: response must be dropped.
    @(negedge clk);
    bus.req_valid = 1; bus.req_store = 0; bus.req_size = 2'd0;
    bus.req_unsigned = 1; bus.req_addr = 32'h21; bus.resp_ready = 0;
    @(negedge clk);
    bus.req_valid = 0;
    for (int n = 0; n < 10 && !bus.resp_valid; n++) @(negedge clk);
    chk("pre_rst_valid", 32'(bus.resp_valid), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_valid", 32'(bus.resp_valid), 0);
    chk("mid_rst_ready", 32'(bus.req_ready), 1);
    bus.resp_ready = 1;
    xact(0, 2'd0, 1, 32'h21, 32'h0, 0, rd, f, lat);
    chk("post_rst_ldb", rd, 32'h00000080);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
